// File: rtl/edge_sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and a single
// output register with valid/ready handshaking on both sides.
module edge_sobel_stream #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned THRESHOLD  = 0
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [10:0]   THR      = 11'(THRESHOLD);

  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic [7:0]    r_lb0 [IMG_WIDTH];
  logic [7:0]    r_lb1 [IMG_WIDTH];
  logic [7:0]    r_win [3][3];
  logic [7:0]    w_win [3][3];
  logic          w_accept, w_trigger, w_first, w_last;
  logic [9:0]    w_gx_p, w_gx_n, w_gy_p, w_gy_n, w_ax, w_ay;
  logic [10:0]   w_mag;
  logic [7:0]    w_pix;
  logic          r_valid, r_sop, r_eop;
  logic [7:0]    r_data;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_valid;
  assign out_sop   = r_sop;
  assign out_eop   = r_eop;
  assign out_data  = r_data;

  // Position of the current beat; a start-of-packet forces (0,0).
  always_comb begin
    w_col     = in_sop ? '0 : r_col;
    w_row     = in_sop ? '0 : r_row;
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
    w_trigger = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
    w_first   = (w_row == RW'(2)) && (w_col == CW'(2));
    w_last    = (w_row == ROW_LAST) && (w_col == COL_LAST);
  end

  // Window after this beat's column shift; the result is computed from it.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r][0] = r_win[r][1];
      w_win[r][1] = r_win[r][2];
    end
    w_win[0][2] = r_lb1[w_col];
    w_win[1][2] = r_lb0[w_col];
    w_win[2][2] = in_data;
  end

  // |Gx| + |Gy| from unsigned positive/negative partial sums.
  always_comb begin
    w_gx_p = 10'(w_win[0][2]) + (10'(w_win[1][2]) << 1) + 10'(w_win[2][2]);
    w_gx_n = 10'(w_win[0][0]) + (10'(w_win[1][0]) << 1) + 10'(w_win[2][0]);
    w_gy_p = 10'(w_win[2][0]) + (10'(w_win[2][1]) << 1) + 10'(w_win[2][2]);
    w_gy_n = 10'(w_win[0][0]) + (10'(w_win[0][1]) << 1) + 10'(w_win[0][2]);
    w_ax   = (w_gx_p >= w_gx_n) ? (w_gx_p - w_gx_n) : (w_gx_n - w_gx_p);
    w_ay   = (w_gy_p >= w_gy_n) ? (w_gy_p - w_gy_n) : (w_gy_n - w_gy_p);
    w_mag  = 11'(w_ax) + 11'(w_ay);
    if (THRESHOLD == 0) begin
      w_pix = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
    end else begin
      w_pix = (w_mag >= THR) ? 8'hFF : 8'h00;
    end
  end

  // Line buffers are never cleared; only in-frame rows reach emitted windows.
  always_ff @(posedge clk_clk) begin
    if (w_accept) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= in_data;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        r_win <= w_win;
      end
      if (w_trigger) begin
        r_valid <= 1'b1;
        r_data  <= w_pix;
        r_sop   <= w_first;
        r_eop   <= w_last;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/edge_sobel_stream.md
EDGE_SOBEL_STREAM -- requirements
Module: edge_sobel_stream

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line; legal range 3..2048.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame; legal range 3..2048.
REQ-003 Parameter THRESHOLD, default 0: 0 selects grey-scale magnitude output; 1..255 selects binary output.
REQ-004 clk_clk  input  1: the only clock; all state updates on its rising edge.
REQ-005 reset_reset_n  input  1: synchronous, active-low reset.
REQ-006 in_data  input  8: unsigned grey-scale input pixel.
REQ-007 in_valid  input  1: in_data and in_sop are valid.
REQ-008 in_sop  input  1: this beat is pixel (row 0, col 0) of a frame.
REQ-009 in_ready  output  1: block accepts a beat this cycle.
REQ-010 out_data  output  8: edge magnitude pixel.
REQ-011 out_valid  output  1: out_data, out_sop and out_eop are valid.
REQ-012 out_ready  input  1: downstream accepts a beat this cycle.
REQ-013 out_sop  output  1: first pixel of an output frame.
REQ-014 out_eop  output  1: last pixel of an output frame.

Function
REQ-015 An input beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1; an output beat SHALL complete only where out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally, giving full throughput with one output register.
REQ-017 Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL give the position of each accepted beat; col wraps to 0 and increments row after IMG_WIDTH-1; row wraps to 0 after IMG_HEIGHT-1.
REQ-018 An accepted beat with in_sop=1 SHALL be treated as (0,0) regardless of counters, aborting any partial frame with no further output from it; in_sop=1 at other positions is otherwise ignored.
REQ-019 Two line buffers of IMG_WIDTH x 8 bits SHALL hold the two previous lines; on each accepted beat, the 3x3 window p[r][c] (r=0 oldest line, c=0 oldest column) SHALL shift one column, loading column 2 with {linebuf1[col], linebuf0[col], in_data}, and line buffers SHALL update at index col.
REQ-020 Gx = (p0,2 + 2*p1,2 + p2,2) - (p0,0 + 2*p1,0 + p2,0); Gy = (p2,0 + 2*p2,1 + p2,2) - (p0,0 + 2*p0,1 + p0,2); both 11-bit signed, range -1020..1020.
REQ-021 mag = |Gx| + |Gy| (11-bit unsigned, 0..2040), saturated to 255; with THRESHOLD=0 out_data = saturated mag, else out_data = 255 when mag >= THRESHOLD and 0 otherwise.
REQ-022 An output beat SHALL be produced only for accepted beats with row>=2 and col>=2, representing centre (row-1, col-1); each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) beats; border pixels are not emitted.
REQ-023 Latency SHALL be 1 cycle: out_valid rises the cycle after acceptance of the triggering beat.
REQ-024 out_sop=1 only for the beat triggered at (2,2); out_eop=1 only for the beat triggered at (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-025 While out_valid=1 and out_ready=0, out_data/out_sop/out_eop SHALL hold stable and no input SHALL be accepted.
REQ-026 When a beat completes and no new trigger is accepted in the same cycle, out_valid SHALL drop next cycle; simultaneous complete plus accept SHALL load the new result without a bubble.

Reset
REQ-027 While reset_reset_n=0 at a rising edge: out_valid=0, out_sop=0, out_eop=0, out_data=0, col=0, row=0, window registers 0; in_ready=1 in the first cycle after reset.
REQ-028 Line buffer contents need not be cleared; any value read before being written in the current frame SHALL not affect emitted output.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the next frame starts only with an in_sop beat or at counter (0,0).

Verification (IMG_WIDTH=8, IMG_HEIGHT=6 unless stated)
REQ-030 Constant frame, all pixels 100, out_ready=1 -> 24 beats, all out_data=0, out_sop on first, out_eop on 24th.
REQ-031 Vertical step, cols 0..3 = 0, cols 4..7 = 255 -> each output row is 0,0,255,255,0,0; with THRESHOLD=128 same pattern.
REQ-032 Single 255 pixel at (2,3), rest 0 -> output centre (2,3) = 0, centre (1,3) = 255 (Gy=510 saturated), centre (2,2) = 255 (Gx=510).
REQ-033 out_ready held 0 for 10 cycles mid-frame -> out_data stable, in_ready=0, final stream identical to the out_ready=1 run.
REQ-034 in_sop asserted at input beat 20 of a frame, then a full constant-50 frame -> aborted frame emits no further beats; new frame emits 24 zero beats with correct sop/eop.
REQ-035 reset_reset_n=0 for 1 cycle at input beat 30 -> out_valid=0 next cycle; the following full frame emits exactly 24 beats.
